// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external combinational RV32I ALU between two requesters.
// Optional grant/conflict statistics are enabled with the ALU_ARBITER_STATS_EN macro.
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_d,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_d,
  output logic [OPW-1:0]   alu_opcode,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_d,
  output logic             busy
`ifdef ALU_ARBITER_STATS_EN
  ,
  output logic [CNT_W-1:0] grant0_cnt,
  output logic [CNT_W-1:0] grant1_cnt,
  output logic [CNT_W-1:0] conflict_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state;
  logic   prio;
  logic   owner;
  logic   winner;
  logic   grant;

  // prio only breaks ties; a lone requester always wins
  always_comb begin
    winner = (req0_valid && req1_valid) ? prio : req1_valid;
    grant  = (state == IDLE) && (req0_valid || req1_valid);
  end

  assign req0_ready = grant && !winner;
  assign req1_ready = grant && winner;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      prio       <= 1'b0;
      owner      <= 1'b0;
      alu_opcode <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_d     <= '0;
      rsp1_d     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            alu_opcode <= winner ? req1_op : req0_op;
            alu_a      <= winner ? req1_a  : req0_a;
            alu_b      <= winner ? req1_b  : req0_b;
            owner      <= winner;
            prio       <= ~winner;
            state      <= EXEC;
          end
        end
        EXEC: begin
          if (owner) begin
            rsp1_d     <= alu_d;
            rsp1_valid <= 1'b1;
          end else begin
            rsp0_d     <= alu_d;
            rsp0_valid <= 1'b1;
          end
          state <= RESP;
        end
        RESP: begin
          if (owner ? rsp1_ready : rsp0_ready) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_ARBITER_STATS_EN
  // counters stick at all-ones instead of wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant0_cnt   <= '0;
      grant1_cnt   <= '0;
      conflict_cnt <= '0;
    end else begin
      if (req0_ready && grant0_cnt != '1)
        grant0_cnt <= grant0_cnt + 1'b1;
      if (req1_ready && grant1_cnt != '1)
        grant1_cnt <= grant1_cnt + 1'b1;
      if (grant && req0_valid && req1_valid && conflict_cnt != '1)
        conflict_cnt <= conflict_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed test-plan steps followed by randomized traffic
// against a transaction-level model; stats checks compile in with ALU_ARBITER_STATS_EN.
module tb_alu_arbiter;

  localparam int CW = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [3:0]  req0_op, req1_op, alu_opcode;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [31:0] rsp0_d, rsp1_d, alu_a, alu_b, alu_d;
  logic        busy;
`ifdef ALU_ARBITER_STATS_EN
  logic [CW-1:0] grant0_cnt, grant1_cnt, conflict_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  // requester-side model state
  logic        pend [2];
  logic [3:0]  pop  [2];
  logic [31:0] pa   [2];
  logic [31:0] pb   [2];
  int          mprio;
  int          mg0, mg1, mconf;
  logic [3:0]  ops [10] = '{4'd0, 4'd8, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd13, 4'd6, 4'd7};

  always #5 clk = ~clk;

  // RV32I ALU behaviour: {arith bit, funct3}
  function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0:    return a + b;
      4'd8:    return a - b;
      4'd1:    return a << b[4:0];
      4'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd3:    return (a < b) ? 32'd1 : 32'd0;
      4'd4:    return a ^ b;
      4'd5:    return a >> b[4:0];
      4'd13:   return $unsigned($signed(a) >>> b[4:0]);
      4'd6:    return a | b;
      4'd7:    return a & b;
      default: return 32'd0;
    endcase
  endfunction

  assign alu_d = alu_fn(alu_opcode, alu_a, alu_b);

  alu_arbiter #(.WIDTH(32), .OPW(4), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_d(rsp0_d),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_d(rsp1_d),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_d(alu_d),
    .busy(busy)
`ifdef ALU_ARBITER_STATS_EN
    , .grant0_cnt(grant0_cnt), .grant1_cnt(grant1_cnt), .conflict_cnt(conflict_cnt)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    req0_valid = pend[0]; req0_op = pop[0]; req0_a = pa[0]; req0_b = pb[0];
    req1_valid = pend[1]; req1_op = pop[1]; req1_a = pa[1]; req1_b = pb[1];
  endtask

  task automatic applyStimulus(input int n, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    pend[n] = 1'b1; pop[n] = op; pa[n] = a; pb[n] = b;
    drive();
  endtask

  task automatic checkStats();
`ifdef ALU_ARBITER_STATS_EN
    checkOutput("grant0_cnt", 32'(grant0_cnt), 32'(mg0));
    checkOutput("grant1_cnt", 32'(grant1_cnt), 32'(mg1));
    checkOutput("conflict_cnt", 32'(conflict_cnt), 32'(mconf));
`endif
  endtask

  function automatic int sat(input int v);
    return (v < (1 << CW) - 1) ? v + 1 : v;
  endfunction

  task automatic doReset();
    rst_n = 1'b0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    drive();
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    mprio = 0; mg0 = 0; mg1 = 0; mconf = 0;
    @(negedge clk); #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_rsp0_valid", rsp0_valid, 0);
    checkOutput("rst_rsp1_valid", rsp1_valid, 0);
    checkOutput("rst_rsp0_d", rsp0_d, 0);
    checkOutput("rst_rsp1_d", rsp1_d, 0);
    checkOutput("rst_alu_opcode", alu_opcode, 0);
    checkOutput("rst_alu_a", alu_a, 0);
    checkOutput("rst_alu_b", alu_b, 0);
    checkStats();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // one full transaction from grant to completion; hold = cycles rsp_ready stays low
  task automatic serve(input int hold);
    int w;
    logic [31:0] exp;
    logic [3:0]  eop;
    logic [31:0] ea, eb;
    w   = (pend[0] && pend[1]) ? mprio : (pend[1] ? 1 : 0);
    eop = pop[w]; ea = pa[w]; eb = pb[w];
    exp = alu_fn(eop, ea, eb);
    #1;
    checkOutput("idle_req0_ready", req0_ready, (w == 0));
    checkOutput("idle_req1_ready", req1_ready, (w == 1));
    checkOutput("idle_busy", busy, 0);
    if (pend[0] && pend[1]) mconf = sat(mconf);
    if (w == 0) mg0 = sat(mg0); else mg1 = sat(mg1);
    @(posedge clk);
    mprio = (w == 0) ? 1 : 0;
    @(negedge clk);
    pend[w] = 1'b0;
    drive();
    if (w == 0) rsp0_ready = (hold == 0); else rsp1_ready = (hold == 0);
    #1;
    checkOutput("exec_busy", busy, 1);
    checkOutput("exec_req0_ready", req0_ready, 0);
    checkOutput("exec_req1_ready", req1_ready, 0);
    checkOutput("exec_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
    checkOutput("exec_alu_opcode", alu_opcode, eop);
    checkOutput("exec_alu_a", alu_a, ea);
    checkOutput("exec_alu_b", alu_b, eb);
    for (int i = 0; i <= hold; i++) begin
      @(negedge clk); #1;
      checkOutput("resp_busy", busy, 1);
      checkOutput("resp_req_ready", {req1_ready, req0_ready}, 0);
      checkOutput("resp_rsp0_valid", rsp0_valid, (w == 0));
      checkOutput("resp_rsp1_valid", rsp1_valid, (w == 1));
      checkOutput("resp_rsp_d", (w == 0) ? rsp0_d : rsp1_d, exp);
    end
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    @(negedge clk); #1;
    checkOutput("done_busy", busy, 0);
    checkOutput("done_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
    checkOutput("done_alu_a_held", alu_a, ea);
    checkStats();
  endtask

  initial begin
    pend[0] = 1'b0; pend[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin pop[i] = '0; pa[i] = '0; pb[i] = '0; end
    drive();
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;

    // single requesters
    doReset();
    @(negedge clk);
    applyStimulus(0, 4'd0, 32'd5, 32'd3);
    serve(0);
    applyStimulus(1, 4'd8, 32'd3, 32'd5);
    serve(0);

    // simultaneous requests from reset: req0, then req1, then req0 again
    doReset();
    applyStimulus(0, 4'd4, 32'hF0, 32'h0F);
    applyStimulus(1, 4'd7, 32'hF0, 32'h3C);
    serve(0);
    serve(0);
    applyStimulus(0, 4'd4, 32'hF0, 32'h0F);
    applyStimulus(1, 4'd7, 32'hF0, 32'h3C);
    serve(0);
    serve(0);

    // backpressure on the response
    applyStimulus(0, 4'd2, 32'hFFFFFFFF, 32'd1);
    serve(5);
    applyStimulus(0, 4'd0, 32'd1, 32'd1);
    serve(0);

    // reset while req1 is executing drops the op
    applyStimulus(1, 4'd1, 32'd1, 32'd4);
    #1;
    checkOutput("mid_req1_ready", req1_ready, 1);
    @(posedge clk);
    @(negedge clk);
    pend[1] = 1'b0;
    drive();
    rst_n = 1'b0;
    mprio = 0; mg0 = 0; mg1 = 0; mconf = 0;
    #1;
    checkOutput("mid_busy", busy, 0);
    checkOutput("mid_alu_opcode", alu_opcode, 0);
    checkOutput("mid_alu_b", alu_b, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checkOutput("mid_rsp1_valid", rsp1_valid, 0);
    end
    rst_n = 1'b1;
    @(negedge clk); #1;
    checkOutput("mid_after_rsp1_valid", rsp1_valid, 0);
    checkStats();
    applyStimulus(0, 4'd6, 32'h1200, 32'h0034);
    serve(0);

    // randomized traffic
    for (int k = 0; k < 60; k++) begin
      for (int n = 0; n < 2; n++)
        if (!pend[n] && ($urandom_range(0, 1) == 1))
          applyStimulus(n, ops[$urandom_range(0, 9)], $urandom, $urandom);
      if (!pend[0] && !pend[1])
        applyStimulus(int'($urandom_range(0, 1)), ops[$urandom_range(0, 9)], $urandom, $urandom);
      serve(int'($urandom_range(0, 2)));
    end
    while (pend[0] || pend[1]) serve(0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
